// File: rtl/am_audio_pkg.sv
// Shared constants and helpers for the AM post-detector audio path.
package am_audio_pkg;

    localparam int unsigned DefWidth     = 12;
    localparam int unsigned DefOutWidth  = 12;
    localparam int unsigned DefDecimLog2 = 6;
    localparam int unsigned DefDcShift   = 10;

    // Clamp a signed value to the range of an out_width-bit two's complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int unsigned out_width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_width - 1));
        if (val > hi) begin
            sat_signed = hi;
        end else if (val < lo) begin
            sat_signed = lo;
        end else begin
            sat_signed = val;
        end
    endfunction

endpackage

// File: rtl/am_dc_tracker.sv
// Stage 2 of the audio path: DC removal, saturation and output strobe registers.
// Optional feature macro: AM_DC_BLOCK_EN (leaky-integrator DC tracker). When undefined the
// DC estimate is the fixed midscale value.
module am_dc_tracker
    import am_audio_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned OUT_WIDTH = DefOutWidth,
    parameter int unsigned DC_SHIFT  = DefDcShift
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     mean,
    input  logic                 mean_v,
    output logic [OUT_WIDTH-1:0] d_out,
    output logic                 d_valid,
    output logic                 clip
);

    localparam int unsigned YW = WIDTH + 1;

    logic signed [YW-1:0]  dc_est;
    logic signed [YW-1:0]  y;
    logic signed [31:0]    y_ext;
    logic signed [31:0]    y_sat;

    logic [OUT_WIDTH-1:0]  d_out_q, d_out_d;
    logic                  d_valid_q, d_valid_d;
    logic                  clip_q, clip_d;

`ifdef AM_DC_BLOCK_EN
    localparam int unsigned AW = WIDTH + DC_SHIFT + 1;
    localparam logic signed [AW-1:0] DcAccInit = AW'(1) << (WIDTH - 1 + DC_SHIFT);

    logic signed [AW-1:0] dc_acc_q, dc_acc_d;

    // Tracker state integrates the unclipped error, only on decimated samples.
    always_comb begin
        dc_est   = YW'(dc_acc_q >>> DC_SHIFT);
        y        = $signed({1'b0, mean}) - dc_est;
        dc_acc_d = dc_acc_q;
        if (mean_v) begin
            dc_acc_d = dc_acc_q + AW'(y);
        end
    end

    // DC accumulator register, restarts at midscale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_acc_q <= DcAccInit;
        end else begin
            dc_acc_q <= dc_acc_d;
        end
    end
`else
    localparam logic signed [YW-1:0] DcMid = YW'(1) << (WIDTH - 1);

    // Fixed midscale DC estimate.
    always_comb begin
        dc_est = DcMid;
        y      = $signed({1'b0, mean}) - dc_est;
    end
`endif

    // Saturate the error and form next output register values.
    always_comb begin
        y_ext     = 32'(y);
        y_sat     = sat_signed(y_ext, OUT_WIDTH);
        d_out_d   = d_out_q;
        clip_d    = 1'b0;
        d_valid_d = mean_v;
        if (mean_v) begin
            d_out_d = OUT_WIDTH'(y_sat);
            clip_d  = (y_sat != y_ext);
        end
    end

    // Output registers; d_out holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            clip_q    <= clip_d;
        end
    end

    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign clip    = clip_q;

endmodule

// File: rtl/am_audio_decim.sv
// AM envelope accumulate-and-dump decimator feeding the DC tracker / saturation stage.
// Optional feature macro: AM_DC_BLOCK_EN (handled inside am_dc_tracker).
module am_audio_decim
    import am_audio_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned OUT_WIDTH  = DefOutWidth,
    parameter int unsigned DECIM_LOG2 = DefDecimLog2,
    parameter int unsigned DC_SHIFT   = DefDcShift
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     d_in,
    output logic [OUT_WIDTH-1:0] d_out,
    output logic                 d_valid,
    output logic                 clip
);

    localparam int unsigned AccW = WIDTH + DECIM_LOG2;

    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic [AccW-1:0]       acc_sum;
    logic [WIDTH-1:0]      mean_q, mean_d;
    logic                  mean_v_q, mean_v_d;
    logic                  dump;

    // Accumulate every sample; on the last sample of a frame fold it into the mean and restart.
    always_comb begin
        acc_sum  = acc_q + AccW'(d_in);
        dump     = (cnt_q == {DECIM_LOG2{1'b1}});
        cnt_d    = cnt_q + DECIM_LOG2'(1);
        acc_d    = acc_sum;
        mean_d   = mean_q;
        mean_v_d = 1'b0;
        if (dump) begin
            cnt_d    = '0;
            acc_d    = '0;
            mean_d   = WIDTH'(acc_sum >> DECIM_LOG2);
            mean_v_d = 1'b1;
        end
    end

    // Decimator state; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mean_q   <= '0;
            mean_v_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mean_q   <= mean_d;
            mean_v_q <= mean_v_d;
        end
    end

    am_dc_tracker #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .DC_SHIFT  (DC_SHIFT)
    ) u_dc_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .mean    (mean_q),
        .mean_v  (mean_v_q),
        .d_out   (d_out),
        .d_valid (d_valid),
        .clip    (clip)
    );

endmodule

// File: tb/tb_am_audio_decim.sv
// Directed bench for am_audio_decim at default parameters; expectations follow AM_DC_BLOCK_EN.
module tb_am_audio_decim;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] d_in = 12'd0;
    logic [11:0] d_out;
    logic        d_valid;
    logic        clip;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ecount;
    logic alt_en = 1'b0;

`ifdef AM_DC_BLOCK_EN
    localparam bit DcOn = 1'b1;
`else
    localparam bit DcOn = 1'b0;
`endif

    always #5 clk = ~clk;

    am_audio_decim #(
        .WIDTH      (12),
        .OUT_WIDTH  (12),
        .DECIM_LOG2 (6),
        .DC_SHIFT   (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_in    (d_in),
        .d_out   (d_out),
        .d_valid (d_valid),
        .clip    (clip)
    );

    // Edge number since reset release (edge 1 is the first sampling edge).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        if (alt_en) d_in = (d_in == 12'd0) ? 12'd4095 : 12'd0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val({tag, "_rst_dout"}, 32'($signed(d_out)), 0);
        check_val({tag, "_rst_valid"}, 32'(d_valid), 0);
        check_val({tag, "_rst_clip"}, 32'(clip), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_edge(input int e);
        while (ecount < e) step_cycle();
    endtask

    // Wait for the next strobe, check its edge and payload, then check it lasts one cycle.
    task automatic expect_frame(input string tag, input int exp_edge, input int exp_out,
                                input int exp_clip);
        int n;
        int at;
        bit seen;
        n = 0;
        at = -1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            step_cycle();
            n++;
            if (d_valid === 1'b1) begin
                seen = 1'b1;
                at = ecount;
            end
        end
        check_val({tag, "_edge"}, at, exp_edge);
        if (seen) begin
            check_val({tag, "_dout"}, 32'($signed(d_out)), exp_out);
            check_val({tag, "_clip"}, 32'(clip), exp_clip);
            step_cycle();
            check_val({tag, "_valid_drop"}, 32'(d_valid), 0);
            check_val({tag, "_clip_drop"}, 32'(clip), 0);
            check_val({tag, "_hold"}, 32'($signed(d_out)), exp_out);
        end
    endtask

    initial begin
        // Midscale input: zero audio, strobes at 65, 129, 193.
        d_in = 12'd2048;
        do_reset("mid");
        expect_frame("mid_f1", 65, 0, 0);
        expect_frame("mid_f2", 129, 0, 0);
        expect_frame("mid_f3", 193, 0, 0);

        // 3072 constant: tracker decays 1024, 1023, 1023, 1022; fixed DC stays at 1024.
        d_in = 12'd3072;
        do_reset("c3k");
        expect_frame("c3k_f1", 65, 1024, 0);
        expect_frame("c3k_f2", 129, DcOn ? 1023 : 1024, 0);
        expect_frame("c3k_f3", 193, DcOn ? 1023 : 1024, 0);
        expect_frame("c3k_f4", 257, DcOn ? 1022 : 1024, 0);

        // One frame of 0 then step to 4095: tracker estimate 2046 gives y=2049 -> clip.
        d_in = 12'd0;
        do_reset("step");
        wait_edge(64);
        d_in = 12'd4095;
        expect_frame("step_f1", 65, -2048, 0);
        expect_frame("step_f2", 129, 2047, DcOn ? 1 : 0);

        // Full-scale input from midscale state.
        d_in = 12'd4095;
        do_reset("full");
        expect_frame("full_f1", 65, 2047, 0);

        // Alternating 0/4095: mean 2047 -> -1; tracker then estimates 2047 -> 0.
        d_in = 12'd0;
        alt_en = 1'b1;
        do_reset("alt");
        expect_frame("alt_f1", 65, -1, 0);
        expect_frame("alt_f2", 129, DcOn ? 0 : -1, 0);
        alt_en = 1'b0;

        // Reset at cnt=30 discards the partial frame; next strobe is edge 65 again.
        d_in = 12'd4095;
        do_reset("mf_a");
        wait_edge(30);
        do_reset("mf_b");
        expect_frame("mf_f1", 65, 2047, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
